// File: rtl/pr_softreg_ctrl_pkg.sv
// pr_softreg_ctrl_pkg
// Shared constants for the PageRank SoftReg control front end: the SoftReg
// address map decoded by the host interface and the controller state encoding.
// No ports; imported by pr_softreg_ctrl and its testbench.
package pr_softreg_ctrl_pkg;

    localparam logic [31:0] ADDR_N_VERT           = 32'h0000_0000;
    localparam logic [31:0] ADDR_N_INEDGES        = 32'h0000_0008;
    localparam logic [31:0] ADDR_VADDR            = 32'h0000_0010;
    localparam logic [31:0] ADDR_IEADDR           = 32'h0000_0018;
    localparam logic [31:0] ADDR_WRITE_ADDR0      = 32'h0000_0020;
    localparam logic [31:0] ADDR_WRITE_ADDR1      = 32'h0000_0028;
    localparam logic [31:0] ADDR_DONE_READ_PARAMS = 32'h0000_0030;
    localparam logic [31:0] ADDR_DONE_ALL         = 32'h0000_0038;
    localparam logic [31:0] ADDR_ITER_COUNT       = 32'h0000_0040;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pr_softreg_ctrl.sv
// pr_softreg_ctrl
// Host-facing control front end of the PageRank accelerator. Decodes SoftReg
// requests into configuration registers, launches the engine, counts
// iterations, ping-pongs the prefix-sum buffers and answers the DONE_ALL read
// with the final sum (deferring it while the engine is still running).
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   softreg_req_*             host request: valid strobe, isWrite, addr, data
//   softreg_resp_valid/data   one-cycle read response
//   cfg_*                     configuration outputs to the datapath/AXI engines
//   start, busy               launch pulse, running indicator
//   iter_count                completed iterations (saturating)
//   iter_done, all_done       engine pulses; total_sum valid with all_done
//
// Build option: PR_SOFTREG_READBACK_EN enables readback of the configuration
// registers and of ITER_COUNT; without it those reads answer 0.
//
// state | meaning
// IDLE  | after reset, configuration writable, waiting for launch
// RUN   | engine running, configuration frozen, iterations counted
// DONE  | engine finished, sum latched, configuration writable again
module pr_softreg_ctrl
    import pr_softreg_ctrl_pkg::*;
#(
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              softreg_req_valid,
    input  logic              softreg_req_isWrite,
    input  logic [31:0]       softreg_req_addr,
    input  logic [63:0]       softreg_req_data,
    output logic              softreg_resp_valid,
    output logic [63:0]       softreg_resp_data,
    output logic [63:0]       cfg_n_vert,
    output logic [63:0]       cfg_n_inedges,
    output logic [63:0]       cfg_vaddr,
    output logic [63:0]       cfg_ieaddr,
    output logic [63:0]       cfg_rd_pfx_addr,
    output logic [63:0]       cfg_wr_pfx_addr,
    output logic              start,
    output logic              busy,
    output logic [ITER_W-1:0] iter_count,
    input  logic              iter_done,
    input  logic              all_done,
    input  logic [63:0]       total_sum
);

    state_t      state, state_nx;
    logic [63:0] wr_addr0, wr_addr1;
    logic [63:0] sum_q;
    logic        sel;
    logic        pending, pending_nx;

    logic        wr_req, rd_req;
    logic        launch, finish, step;
    logic        resp_fire;
    logic [63:0] resp_val;

    assign wr_req = softreg_req_valid &&  softreg_req_isWrite;
    assign rd_req = softreg_req_valid && !softreg_req_isWrite;

    assign busy            = (state == ST_RUN);
    assign cfg_wr_pfx_addr = sel ? wr_addr1 : wr_addr0;
    assign cfg_rd_pfx_addr = sel ? wr_addr0 : wr_addr1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        finish   = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (wr_req && softreg_req_addr == ADDR_DONE_READ_PARAMS) begin
                    state_nx = ST_RUN;
                    launch   = 1'b1;
                end
            end
            ST_RUN: begin
                // a coincident iter_done is still counted on the exit edge
                step = iter_done;
                if (all_done) begin
                    state_nx = ST_DONE;
                    finish   = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read handling. While a DONE_ALL read is parked, every other read is
    // dropped, so the deferred answer can never collide with a fresh one.
    always_comb begin
        resp_fire  = 1'b0;
        resp_val   = '0;
        pending_nx = pending;
        if (pending) begin
            if (finish) begin
                resp_fire  = 1'b1;
                resp_val   = total_sum;
                pending_nx = 1'b0;
            end
        end else if (rd_req) begin
            resp_fire = 1'b1;
            case (softreg_req_addr)
                ADDR_DONE_ALL: begin
                    if (state == ST_DONE) begin
                        resp_val = sum_q;
                    end else if (finish) begin
                        resp_val = total_sum;
                    end else begin
                        resp_fire  = 1'b0;
                        pending_nx = 1'b1;
                    end
                end
`ifdef PR_SOFTREG_READBACK_EN
                ADDR_N_VERT:      resp_val = cfg_n_vert;
                ADDR_N_INEDGES:   resp_val = cfg_n_inedges;
                ADDR_VADDR:       resp_val = cfg_vaddr;
                ADDR_IEADDR:      resp_val = cfg_ieaddr;
                ADDR_WRITE_ADDR0: resp_val = wr_addr0;
                ADDR_WRITE_ADDR1: resp_val = wr_addr1;
                ADDR_ITER_COUNT:  resp_val = 64'(iter_count);
`endif
                default:          resp_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_n_vert    <= '0;
            cfg_n_inedges <= '0;
            cfg_vaddr     <= '0;
            cfg_ieaddr    <= '0;
            wr_addr0      <= '0;
            wr_addr1      <= '0;
        end else if (wr_req && state != ST_RUN) begin
            case (softreg_req_addr)
                ADDR_N_VERT:      cfg_n_vert    <= softreg_req_data;
                ADDR_N_INEDGES:   cfg_n_inedges <= softreg_req_data;
                ADDR_VADDR:       cfg_vaddr     <= softreg_req_data;
                ADDR_IEADDR:      cfg_ieaddr    <= softreg_req_data;
                ADDR_WRITE_ADDR0: wr_addr0      <= softreg_req_data;
                ADDR_WRITE_ADDR1: wr_addr1      <= softreg_req_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start      <= 1'b0;
            iter_count <= '0;
            sel        <= 1'b0;
            sum_q      <= '0;
        end else begin
            start <= launch;
            if (launch) begin
                iter_count <= '0;
                sel        <= 1'b0;
                sum_q      <= '0;
            end else begin
                if (step) begin
                    sel <= ~sel;
                    if (iter_count != '1) iter_count <= iter_count + 1'b1;
                end
                if (finish) sum_q <= total_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending            <= 1'b0;
            softreg_resp_valid <= 1'b0;
            softreg_resp_data  <= '0;
        end else begin
            pending            <= pending_nx;
            softreg_resp_valid <= resp_fire;
            if (resp_fire) softreg_resp_data <= resp_val;
        end
    end

endmodule

// File: doc/pr_softreg_ctrl.md
# pr_softreg_ctrl

Host-facing control front end of the PageRank accelerator: decodes SoftReg requests into configuration registers, launches the engine, and tracks iterations. It also manages the ping-pong prefix-sum buffers and answers the final DONE_ALL read with the total sum. It sits between the SoftReg port of the PageRank top and its datapath/AXI engines.

## Interface
- ITER_W, 16, width of the iteration counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- softreg_req_valid  in  1  request strobe, one request per cycle, no backpressure
- softreg_req_isWrite  in  1  1 = write, 0 = read
- softreg_req_addr  in  32  register address (constants-header macros)
- softreg_req_data  in  64  write data
- softreg_resp_valid  out  1  one-cycle read response strobe
- softreg_resp_data  out  64  read response data
- cfg_n_vert, cfg_n_inedges  out  64  vertex / in-edge counts
- cfg_vaddr, cfg_ieaddr  out  64  byte base addresses of the vertex and in-edge arrays
- cfg_rd_pfx_addr, cfg_wr_pfx_addr  out  64  previous-iteration read buffer and current write buffer
- start  out  1  one-cycle engine launch pulse
- busy  out  1  high in RUN
- iter_count  out  ITER_W  completed iterations
- iter_done  in  1  engine pulse: one iteration finished
- all_done  in  1  engine pulse: convergence/finish
- total_sum  in  64  final sum, valid while all_done is high

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE: writes to N_VERT, N_INEDGES, VADDR, IEADDR, WRITE_ADDR0, and WRITE_ADDR1 load the matching register unmodified.
- IDLE/DONE: a write to DONE_READ_PARAMS (data ignored) → RUN. It pulses start the next cycle and clears iter_count, sel, and the latched sum.
- RUN: all writes are ignored; the configuration is frozen.
- Ping-pong: sel = 0 → wr = WRITE_ADDR0, rd = WRITE_ADDR1; sel = 1 → swapped. iter_done in RUN toggles sel and increments iter_count, saturating at all-ones.
- RUN with all_done → DONE; total_sum is latched. If iter_done and all_done arrive in the same cycle, the iteration is counted first, then the transition happens.
- DONE_ALL read in DONE: respond with the latched sum.
- DONE_ALL read in IDLE/RUN: set pending. Respond on the cycle after DONE is entered.
- Only one pending read at a time. Further reads while pending are dropped with no response.
- Reads of any other address: see Configuration.
- Writes to unknown addresses are ignored. Reads of unknown addresses respond with 0.

## Timing
- Reset values: all cfg_* = 0, start = 0, busy = 0, iter_count = 0, softreg_resp_valid = 0, softreg_resp_data = 0, sel = 0, pending = 0, state = IDLE.
- Write at edge N: the register updates at edge N; the new value is visible from cycle N+1.
- DONE_READ_PARAMS at edge N: busy is high and start is high from N+1; start drops at N+2.
- Read at edge N in DONE: resp_valid is high for exactly cycle N+1.
- all_done at edge N with a read pending, or with a DONE_ALL read at edge N: resp_valid is high in cycle N+1 with the new sum.
- cfg_rd/wr_pfx_addr swap the cycle after iter_done is sampled.
- Reset mid-RUN or with a read pending returns immediately to reset values; no response is issued.

## Configuration
- PR_SOFTREG_READBACK_EN
  - Defined: reads of N_VERT, N_INEDGES, VADDR, IEADDR, WRITE_ADDR0, and WRITE_ADDR1 return the register value with 1-cycle latency in any state. A read of ITER_COUNT returns iter_count, zero-extended.
  - Undefined: those reads still respond within 1 cycle, with data 0. Only DONE_ALL returns real data.

## Structure
- Shared constants header: all SoftReg address macros (N_VERT, N_INEDGES, VADDR, IEADDR, WRITE_ADDR0, WRITE_ADDR1, DONE_READ_PARAMS, DONE_ALL, new ITER_COUNT) and the IDLE/RUN/DONE state encoding.
- Single module; no sub-module needed. The ping-pong select is a local flop, not a separate block.

## Test plan
- Param load: write N_VERT = 10, N_INEDGES = 56, VADDR = 0, IEADDR = 160, WRITE_ADDR0 = 1240, WRITE_ADDR1 = 1360, then DONE_READ_PARAMS.
  - Required: cfg outputs match; start is high for exactly one cycle; busy = 1; wr = 1240, rd = 1360.
- Ping-pong: three iter_done pulses.
  - Required: iter_count = 3; wr = 1360, rd = 1240; addresses swap one cycle after each pulse.
- Early DONE_ALL read in RUN, all_done with total_sum = 0x1234 five cycles later.
  - Required: no response until then; resp_valid is high one cycle after all_done, with data 0x1234.
- Frozen config: write N_VERT = 99 during RUN.
  - Required: cfg_n_vert stays 10; a read with READBACK_EN returns 10, or 0 without it.
- Simultaneous iter_done + all_done at iter_count = 2.
  - Required: iter_count = 3, state DONE, sum latched.
- Reset asserted with a read pending.
  - Required: all outputs return to reset values; no resp_valid after rst deasserts; the parameter sequence must be rerun to start again.
